// File: rtl/square_gen.sv
// square_gen: per-square move generator with a LIFO move stack and sliding-piece ray relay.
// Optional feature macro: SQUARE_PROMO_EN expands a promoting pawn move into Q, R, B, N entries.
module square_gen #(
    parameter int unsigned STACK_DEPTH = 16,
    localparam int unsigned CW = $clog2(STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          new_original,
    input  logic [9:0]    original_piece,
    input  logic          collect_pieces,
    input  logic [159:0]  rx_moves,
    input  logic          stack_read,
    output logic [159:0]  tx_moves,
    output logic [15:0]   stack_arbiter,
    output logic          stack_empty,
    output logic          stack_full,
    output logic [CW-1:0] stack_count,
    output logic          busy,
    output logic          overflow
);
    localparam int unsigned AW = $clog2(STACK_DEPTH);

    localparam logic [2:0] T_EMPTY  = 3'd0;
    localparam logic [2:0] T_PAWN   = 3'd1;
    localparam logic [2:0] T_KNIGHT = 3'd2;
    localparam logic [2:0] T_BISHOP = 3'd3;
    localparam logic [2:0] T_ROOK   = 3'd4;
    localparam logic [2:0] T_QUEEN  = 3'd5;
    localparam logic [2:0] T_KING   = 3'd6;

    typedef enum logic [1:0] {StIdle, StScan, StPromo} state_e;

    state_e        state_q;
    logic [9:0]    occ_q;
    logic [159:0]  snap_q;
    logic [3:0]    idx_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic [15:0]   stack_q [STACK_DEPTH];
`ifdef SQUARE_PROMO_EN
    logic [1:0]    pp_q;
    logic [15:0]   promo_word_q;
    logic          promo_last_q;
`endif

    logic [9:0]  mover;
    logic [3:0]  dc, dr;
    logic        adj, occ_empty, shape_ok, move_valid, promoting;
    logic [15:0] move_word, push_word;
    logic        push_en;
    logic [AW-1:0] top_idx, wr_idx;

    assign mover = snap_q[32'(idx_q) * 10 +: 10];

    always_comb begin
        dc        = {1'b0, mover[6:4]} - {1'b0, occ_q[6:4]};
        dr        = {1'b0, mover[3:1]} - {1'b0, occ_q[3:1]};
        adj       = (dc == 4'd0 || dc == 4'd1 || dc == 4'hF) &&
                    (dr == 4'd0 || dr == 4'd1 || dr == 4'hF);
        occ_empty = occ_q[9:7] == T_EMPTY;
        shape_ok  = 1'b0;
        case (mover[9:7])
            T_PAWN: begin
                // Pawns push straight only onto an empty square, diagonally only to capture
                if (!mover[0]) begin
                    shape_ok = adj && ((idx_q == 4'd4 && occ_empty) ||
                                       ((idx_q == 4'd3 || idx_q == 4'd5) && !occ_empty));
                end else begin
                    shape_ok = adj && ((idx_q == 4'd0 && occ_empty) ||
                                       ((idx_q == 4'd1 || idx_q == 4'd7) && !occ_empty));
                end
            end
            T_KNIGHT: shape_ok = idx_q[3];
            T_BISHOP: shape_ok = !idx_q[3] && idx_q[0];
            T_ROOK:   shape_ok = !idx_q[3] && !idx_q[0];
            T_QUEEN:  shape_ok = !idx_q[3];
            T_KING:   shape_ok = !idx_q[3] && adj;
            default:  shape_ok = 1'b0;
        endcase
        move_valid = (mover[9:7] != T_EMPTY) && (occ_empty || occ_q[0] != mover[0]) && shape_ok;
        promoting  = (mover[9:7] == T_PAWN) &&
                     (mover[0] ? (occ_q[3:1] == 3'd0) : (occ_q[3:1] == 3'd7));
        move_word  = {2'b00, promoting, !occ_empty, mover[6:4], mover[3:1], occ_q[6:4], occ_q[3:1]};
    end

    always_comb begin
        push_en   = (state_q == StScan) && move_valid;
        push_word = move_word;
`ifdef SQUARE_PROMO_EN
        if (state_q == StPromo) begin
            push_en   = 1'b1;
            push_word = {pp_q, promo_word_q[13:0]};
        end
`endif
    end

    assign stack_empty   = count_q == '0;
    assign stack_full    = count_q == CW'(STACK_DEPTH);
    assign stack_count   = count_q;
    assign top_idx       = AW'(count_q - 1'b1);
    assign wr_idx        = AW'(count_q);
    assign stack_arbiter = stack_empty ? 16'h0000 : stack_q[top_idx];
    assign busy          = state_q != StIdle;
    assign overflow      = overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            occ_q        <= '0;
            snap_q       <= '0;
            idx_q        <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
`ifdef SQUARE_PROMO_EN
            pp_q         <= '0;
            promo_word_q <= '0;
            promo_last_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (new_original) occ_q <= original_piece;
                    if (collect_pieces) begin
                        snap_q     <= rx_moves;
                        count_q    <= '0;
                        overflow_q <= 1'b0;
                        idx_q      <= '0;
                        state_q    <= StScan;
                    end else if (stack_read && !stack_empty) begin
                        count_q <= count_q - 1'b1;
                    end
                end
                StScan: begin
                    idx_q <= idx_q + 4'd1;
`ifdef SQUARE_PROMO_EN
                    if (move_valid && promoting) begin
                        pp_q         <= 2'd1;
                        promo_word_q <= move_word;
                        promo_last_q <= idx_q == 4'hF;
                        state_q      <= StPromo;
                    end else
`endif
                    if (idx_q == 4'hF) state_q <= StIdle;
                end
`ifdef SQUARE_PROMO_EN
                StPromo: begin
                    pp_q <= pp_q + 2'd1;
                    if (pp_q == 2'd3) state_q <= promo_last_q ? StIdle : StScan;
                end
`endif
                default: state_q <= StIdle;
            endcase
            if (push_en) begin
                if (stack_full) overflow_q <= 1'b1;
                else            count_q    <= count_q + 1'b1;
            end
        end
    end

    // Stack storage needs no reset: entries above count are never observed
    always_ff @(posedge clk) begin
        if (push_en && !stack_full) stack_q[wr_idx] <= push_word;
    end

    logic [9:0] relay_src;
    always_comb begin
        relay_src = '0;
        for (int d = 0; d < 16; d++) tx_moves[10*d +: 10] = occ_q;
        if (occ_q[9:7] == T_EMPTY) begin
            for (int d = 0; d < 8; d++) begin
                relay_src = rx_moves[10*((d+4)%8) +: 10];
                if (relay_src[9:7] == T_BISHOP || relay_src[9:7] == T_ROOK ||
                    relay_src[9:7] == T_QUEEN) begin
                    tx_moves[10*d +: 10] = relay_src;
                end
            end
        end
    end
endmodule

// File: doc/square_gen.md
# square_gen

Parametrised per-square move generator with a move stack. Latches this square's occupant, snapshots the 16 neighbour piece channels on request, and scans them one per cycle. Each legal move or capture onto this square is pushed onto a LIFO that the move arbiter pops. It also relays sliding pieces across the square when it is empty, forming the board-wide ray network.

## Interface
- STACK_DEPTH, 16, number of move entries held; ≥2.
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- new_original  in  1  in IDLE, latch original_piece as occupant.
- original_piece  in  10  occupant {type[2:0], col[2:0], row[2:0], color}; col/row are this square's coordinates even when type is EMPTY.
- collect_pieces  in  1  in IDLE: snapshot rx_moves, clear stack and overflow, start scan.
- rx_moves  in  160  16 piece words; channel i at bits [10i+9:10i].
- stack_read  in  1  in IDLE: pop top entry.
- tx_moves  out  160  16 outgoing piece words to neighbours.
- stack_arbiter  out  16  top-of-stack move; 0 when empty.
- stack_empty  out  1  stack holds no entries.
- stack_full  out  1  stack holds STACK_DEPTH entries.
- stack_count  out  $clog2(STACK_DEPTH+1)  entries held.
- busy  out  1  scan in progress.
- overflow  out  1  sticky: a valid move was dropped because the stack was full.

## Operation
- Encodings:
  - type: EMPTY=0, PAWN=1, KNIGHT=2, BISHOP=3, ROOK=4, QUEEN=5, KING=6.
  - col: A..H=0..7; row: ONE..EIGHT=0..7; WHITE=0, BLACK=1.
- Move word: {promo_piece[1:0], promo, capture, src_col, src_row, dst_col, dst_row}.
  - promo_piece: 00=Q, 01=R, 10=B, 11=N.
  - promo_piece is 0 when promo=0.
- Channels give the mover's location relative to this square:
  - 0=N, 1=NE, 2=E, 3=SE, 4=S, 5=SW, 6=W, 7=NW.
  - 8..15 are knight offsets.
- Validity of channel i:
  - Mover type ≠ EMPTY.
  - Occupant is EMPTY or of the opposite colour; capture = occupant non-EMPTY.
  - KNIGHT: channels 8..15 only.
  - ROOK: 0,2,4,6; BISHOP: 1,3,5,7; QUEEN: 0..7; all at any distance.
  - KING: 0..7 with |dcol|,|drow| ≤ 1.
  - White PAWN: ch4 at distance 1 with occupant EMPTY, or ch3/ch5 at distance 1 as a capture.
  - Black PAWN: mirrored, using ch0 and ch1/ch7.
  - Pawn double pushes are not generated here.
- FSM states:
  - IDLE → SCAN on collect_pieces.
  - SCAN: scan index 0..15, one channel per cycle, ascending. A valid move pushes one entry.
  - SCAN → PROMO when a pawn reaches row EIGHT (white) or ONE (black) and SQUARE_PROMO_EN is set. PROMO pushes the remaining 3 promotion entries, then resumes SCAN.
  - SCAN → IDLE after index 15.
- Push while full: entry dropped, overflow←1, scan continues.
- In SCAN/PROMO, new_original, collect_pieces and stack_read are ignored.
- stack_read when empty: no effect.
- new_original and collect_pieces together in IDLE: the scan uses the newly latched occupant.
- tx_moves is combinational. For ray channel d (0..7):
  - Occupant EMPTY and rx channel (d+4)%8 holds a BISHOP, ROOK or QUEEN: forward that piece.
  - Otherwise: send the occupant word.
  - Channels 8..15 always carry the occupant word.

## Timing
- Reset values:
  - occupant = 0, stack empty, stack_count = 0, stack_arbiter = 0.
  - stack_empty = 1, stack_full = 0, busy = 0, overflow = 0, FSM IDLE.
  - tx_moves = 0.
- collect_pieces sampled at edge k: busy=1 from k through k+16 (plus 3 cycles per PROMO episode), stack cleared at k.
- The push for scan index j is visible after edge k+1+j.
- Pop updates stack_arbiter and stack_count on the edge after stack_read.
- rst asserted mid-scan returns all state to reset values immediately; the scan is abandoned.

## Configuration
- SQUARE_PROMO_EN defined: a promoting pawn move pushes 4 entries, Q, R, B, N in that order, so N ends on top. Each entry costs one cycle (3 extra cycles).
- Undefined: a single entry with promo=1, promo_piece=00 (queen).

## Test plan
- Occupant WHITE PAWN C4; rx ch4=BLACK KNIGHT C3, ch2=WHITE KNIGHT D4, ch0=BLACK BISHOP C5, ch6=BLACK ROOK B4, ch7=BLACK BISHOP B5.
  - After collect: busy for 16 cycles, stack_count=2, stack_arbiter=0x1313.
  - Pop → 0x12D3; pop → stack_empty=1, stack_arbiter=0.
- Occupant EMPTY E8; rx ch4=WHITE PAWN E7.
  - With SQUARE_PROMO_EN: count=4, top=0xE9A7, busy 19 cycles.
  - Without SQUARE_PROMO_EN: count=1, top=0x29A7.
- STACK_DEPTH=2 with three valid channels: stack_full=1, overflow=1, third move dropped. Next collect clears overflow.
- Occupant EMPTY D4 with rx ch6=WHITE ROOK A4: tx ch2 = rook word.
  - Same with rx ch6 = KNIGHT: tx ch2 = occupant word.
- rst pulsed at scan index 5: all outputs return to reset values that cycle.
- stack_read and collect_pieces pulsed during SCAN: no pop, scan not restarted, final count unchanged.
